// File: rtl/sata_phy_if_mc_if.sv
// rtl/sata_phy_if_mc_if.sv - link-layer / transceiver signal bundle for sata_phy_if_mc
//
// Purpose: groups every per-channel TX, RX and link-state signal of the
//          multi-channel SATA PHY shim into one interface.
// Signals (all vectors are C_NUM_CH channels wide, channel i in the i-th slice):
//   link_up         per-channel OOB link-up
//   cs2phy_data     TX dword from link layer (32 bits/channel)
//   fsm2phy_k       TX dword is a primitive
//   tx_pop          TX dword consumed this cycle
//   txdata_fis      GTX TXDATA (32 bits/channel)
//   tx_charisk_fis  GTX TXCHARISK (4 bits/channel)
//   rxdata_fis      raw GTX RXDATA (32 bits/channel)
//   rxcharisk       raw GTX RXCHARISK (4 bits/channel)
//   phy2cs_data     aligned RX dword (32 bits/channel)
//   phy2cs_k        aligned dword is a primitive
//   phy2cs_valid    aligned dword is valid and not ALIGN
//   rx_aligned      comma lane locked
//   rx_lane         locked comma byte lane (2 bits/channel)
//   rx_realign_cnt  saturating lane-change count (8 bits/channel)
// Modports: master = link layer + transceiver side, slave = the shim.
interface sata_phy_if_mc_if #(
   parameter int C_NUM_CH = 2
);
   logic [C_NUM_CH-1:0]     link_up;
   logic [32*C_NUM_CH-1:0]  cs2phy_data;
   logic [C_NUM_CH-1:0]     fsm2phy_k;
   logic [C_NUM_CH-1:0]     tx_pop;
   logic [32*C_NUM_CH-1:0]  txdata_fis;
   logic [4*C_NUM_CH-1:0]   tx_charisk_fis;
   logic [32*C_NUM_CH-1:0]  rxdata_fis;
   logic [4*C_NUM_CH-1:0]   rxcharisk;
   logic [32*C_NUM_CH-1:0]  phy2cs_data;
   logic [C_NUM_CH-1:0]     phy2cs_k;
   logic [C_NUM_CH-1:0]     phy2cs_valid;
   logic [C_NUM_CH-1:0]     rx_aligned;
   logic [2*C_NUM_CH-1:0]   rx_lane;
   logic [8*C_NUM_CH-1:0]   rx_realign_cnt;

   modport master (
      output link_up, cs2phy_data, fsm2phy_k, rxdata_fis, rxcharisk,
      input  tx_pop, txdata_fis, tx_charisk_fis,
      input  phy2cs_data, phy2cs_k, phy2cs_valid, rx_aligned, rx_lane, rx_realign_cnt
   );

   modport slave (
      input  link_up, cs2phy_data, fsm2phy_k, rxdata_fis, rxcharisk,
      output tx_pop, txdata_fis, tx_charisk_fis,
      output phy2cs_data, phy2cs_k, phy2cs_valid, rx_aligned, rx_lane, rx_realign_cnt
   );
endinterface

// File: rtl/sata_phy_if_mc.sv
// rtl/sata_phy_if_mc.sv - multi-channel SATA PHY shim: TX ALIGN insertion, RX comma alignment
//
// Purpose: for each of C_NUM_CH independent channels, registers link-layer
//          dwords onto the GTX TX port while inserting an ALIGN pair at the end
//          of every C_ALIGN_PERIOD-dword window (backpressuring upstream via
//          tx_pop), and on RX locks onto the K28.5 comma lane, rotates raw
//          words into dword alignment and flags ALIGN primitives as not valid.
// Ports:
//   clk_75m   in   shared phy clock
//   host_rst  in   synchronous active-high reset
//   bus       sata_phy_if_mc_if.slave - link_up, TX and RX channel vectors
module sata_phy_if_mc #(
   parameter int          C_NUM_CH       = 2,
   parameter int          C_ALIGN_PERIOD = 256,
   parameter logic [31:0] C_ALIGN_PRIM   = 32'h7B4A4ABC
) (
   input  logic            clk_75m,
   input  logic            host_rst,
   sata_phy_if_mc_if.slave bus
);

   localparam int                 C_CNT_W       = $clog2(C_ALIGN_PERIOD);
   // First of the two ALIGN slots at the tail of each window.
   localparam logic [C_CNT_W-1:0] C_FIRST_ALIGN = C_CNT_W'(C_ALIGN_PERIOD - 2);
   localparam logic [7:0]         C_K28_5       = 8'hBC;

   // TX state
   logic [C_CNT_W-1:0] r_wcnt      [C_NUM_CH];
   logic [31:0]        r_txdata    [C_NUM_CH];
   logic [3:0]         r_txk       [C_NUM_CH];

   // RX state
   logic [31:0]        r_prevword  [C_NUM_CH];
   logic [3:0]         r_prevk     [C_NUM_CH];
   logic [31:0]        r_rxdata    [C_NUM_CH];
   logic               r_rxk       [C_NUM_CH];
   logic               r_rxvalid   [C_NUM_CH];
   logic               r_aligned   [C_NUM_CH];
   logic [1:0]         r_lane      [C_NUM_CH];
   logic [7:0]         r_realign   [C_NUM_CH];

   // Per-channel combinational decode
   logic               w_link      [C_NUM_CH];
   logic               w_data_slot [C_NUM_CH];
   logic [31:0]        w_txin      [C_NUM_CH];
   logic               w_txin_k    [C_NUM_CH];
   logic [31:0]        w_cur       [C_NUM_CH];
   logic [3:0]         w_curk      [C_NUM_CH];
   logic               w_comma     [C_NUM_CH];
   logic [1:0]         w_comma_lane[C_NUM_CH];
   logic               w_realign   [C_NUM_CH];
   logic [31:0]        w_rot_data  [C_NUM_CH];
   logic [3:0]         w_rot_k     [C_NUM_CH];
   logic               w_is_align  [C_NUM_CH];

   always_comb begin
      for (int i = 0; i < C_NUM_CH; i++) begin
         w_link[i]       = bus.link_up[i];
         w_data_slot[i]  = (r_wcnt[i] < C_FIRST_ALIGN);
         w_txin[i]       = bus.cs2phy_data[32*i +: 32];
         w_txin_k[i]     = bus.fsm2phy_k[i];
         w_cur[i]        = bus.rxdata_fis[32*i +: 32];
         w_curk[i]       = bus.rxcharisk[4*i +: 4];

         // A comma needs exactly one K bit set and that byte equal to K28.5;
         // multi-hot charisk words never qualify.
         w_comma[i]      = 1'b0;
         w_comma_lane[i] = 2'd0;
         case (w_curk[i])
            4'b0001: begin
               w_comma_lane[i] = 2'd0;
               w_comma[i]      = (w_cur[i][7:0] == C_K28_5);
            end
            4'b0010: begin
               w_comma_lane[i] = 2'd1;
               w_comma[i]      = (w_cur[i][15:8] == C_K28_5);
            end
            4'b0100: begin
               w_comma_lane[i] = 2'd2;
               w_comma[i]      = (w_cur[i][23:16] == C_K28_5);
            end
            4'b1000: begin
               w_comma_lane[i] = 2'd3;
               w_comma[i]      = (w_cur[i][31:24] == C_K28_5);
            end
            default: begin
               w_comma[i]      = 1'b0;
            end
         endcase

         // {cur, prev} shifted right by the lane byte count puts the comma
         // byte at bit 0; lane 0 therefore selects prev unchanged.
         w_rot_data[i] = 32'({w_cur[i], r_prevword[i]} >> {r_lane[i], 3'b000});
         w_rot_k[i]    = 4'({w_curk[i], r_prevk[i]} >> r_lane[i]);
         w_is_align[i] = (w_rot_data[i] == C_ALIGN_PRIM) && (w_rot_k[i] == 4'b0001);

         // Lane change while already locked: the word produced this cycle
         // straddles two alignments and is discarded.
         w_realign[i]  = w_comma[i] && r_aligned[i] && (w_comma_lane[i] != r_lane[i]);
      end
   end

   always_comb begin
      bus.tx_pop         = '0;
      bus.txdata_fis     = '0;
      bus.tx_charisk_fis = '0;
      bus.phy2cs_data    = '0;
      bus.phy2cs_k       = '0;
      bus.phy2cs_valid   = '0;
      bus.rx_aligned     = '0;
      bus.rx_lane        = '0;
      bus.rx_realign_cnt = '0;
      for (int i = 0; i < C_NUM_CH; i++) begin
         // Pop is combinational so upstream can advance in the same cycle.
         bus.tx_pop[i]                  = !host_rst && w_link[i] && w_data_slot[i];
         bus.txdata_fis[32*i +: 32]     = r_txdata[i];
         bus.tx_charisk_fis[4*i +: 4]   = r_txk[i];
         bus.phy2cs_data[32*i +: 32]    = r_rxdata[i];
         bus.phy2cs_k[i]                = r_rxk[i];
         bus.phy2cs_valid[i]            = r_rxvalid[i];
         bus.rx_aligned[i]              = r_aligned[i];
         bus.rx_lane[2*i +: 2]          = r_lane[i];
         bus.rx_realign_cnt[8*i +: 8]   = r_realign[i];
      end
   end

   always_ff @(posedge clk_75m) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
         if (host_rst) begin
            r_wcnt[i]     <= '0;
            r_txdata[i]   <= C_ALIGN_PRIM;
            r_txk[i]      <= 4'b0001;
            r_prevword[i] <= '0;
            r_prevk[i]    <= '0;
            r_rxdata[i]   <= '0;
            r_rxk[i]      <= 1'b0;
            r_rxvalid[i]  <= 1'b0;
            r_aligned[i]  <= 1'b0;
            r_lane[i]     <= 2'd0;
            r_realign[i]  <= 8'd0;
         end else begin
            // TX: window counter wraps naturally because the period is a
            // power of two; link down parks it at the window start.
            if (!w_link[i]) begin
               r_wcnt[i]   <= '0;
               r_txdata[i] <= C_ALIGN_PRIM;
               r_txk[i]    <= 4'b0001;
            end else begin
               r_wcnt[i] <= r_wcnt[i] + 1'b1;
               if (w_data_slot[i]) begin
                  r_txdata[i] <= w_txin[i];
                  r_txk[i]    <= {3'b000, w_txin_k[i]};
               end else begin
                  r_txdata[i] <= C_ALIGN_PRIM;
                  r_txk[i]    <= 4'b0001;
               end
            end

            // RX: data/k follow the rotator every cycle; only valid is gated.
            r_rxdata[i] <= w_rot_data[i];
            r_rxk[i]    <= (w_rot_k[i] == 4'b0001);
            if (!w_link[i]) begin
               r_aligned[i]  <= 1'b0;
               r_lane[i]     <= 2'd0;
               r_rxvalid[i]  <= 1'b0;
               r_prevword[i] <= '0;
               r_prevk[i]    <= '0;
            end else begin
               r_prevword[i] <= w_cur[i];
               r_prevk[i]    <= w_curk[i];
               r_rxvalid[i]  <= r_aligned[i] && !w_is_align[i] && !w_realign[i];
               if (w_comma[i]) begin
                  if (!r_aligned[i]) begin
                     r_aligned[i] <= 1'b1;
                     r_lane[i]    <= w_comma_lane[i];
                  end else if (w_comma_lane[i] != r_lane[i]) begin
                     r_lane[i] <= w_comma_lane[i];
                     if (r_realign[i] != 8'hFF) begin
                        r_realign[i] <= r_realign[i] + 8'd1;
                     end
                  end
               end
            end
         end
      end
   end

endmodule
